// File: rtl/count_pkg.sv
// ============================================================================
// count_pkg : types shared by the count_sampler slice and the counter stage.
// Rev 1.0
// ============================================================================
`default_nettype none

package count_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENABLE  = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } sampler_state_t;

  typedef struct packed {
    logic [COUNT_W-1:0] wrap;
    logic [COUNT_W-1:0] q;
  } sample_word_t;

endpackage

`default_nettype wire

// File: rtl/rel_edge_counter.sv
// ============================================================================
// rel_edge_counter : counts rising edges of the counter wrap pulse (epoch).
// Optional sticky overflow flag under COUNT_SAMPLER_OVF_STICKY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module rel_edge_counter
  import count_pkg::*;
#(
  parameter int WRAP_W = COUNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rel,
`ifdef COUNT_SAMPLER_OVF_STICKY_EN
  input  logic              ovf_clr,
  output logic              ovf,
`endif
  output logic [WRAP_W-1:0] wrap_cnt
);

  logic              rel_d_q;
  logic              rel_rise;
  logic [WRAP_W-1:0] wrap_cnt_q;
  logic [WRAP_W-1:0] wrap_cnt_d;

  always_comb begin
    rel_rise   = rel & ~rel_d_q;
    wrap_cnt_d = wrap_cnt_q + WRAP_W'(rel_rise);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rel_d_q    <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      rel_d_q    <= rel;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;

`ifdef COUNT_SAMPLER_OVF_STICKY_EN
  logic ovf_q;
  logic ovf_d;

  // A wrap on the same edge as a clear must not be lost.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (rel_rise && (&wrap_cnt_q)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: rtl/count_sampler.sv
// ============================================================================
// count_sampler : enables the counter bus on request, captures {wrap, q} and
// presents it on a valid/ready port. Option: COUNT_SAMPLER_OVF_STICKY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module count_sampler
  import count_pkg::*;
#(
  parameter int Q_W        = COUNT_W,
  parameter int WRAP_W     = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [Q_W-1:0]        q_bus,
  input  logic                  rel,
  output logic                  n_op_en,
  input  logic                  sample_req,
  output logic                  busy,
  output logic [WRAP_W+Q_W-1:0] data_out,
  output logic                  data_valid,
`ifdef COUNT_SAMPLER_OVF_STICKY_EN
  input  logic                  ovf_clr,
  output logic                  ovf,
`endif
  input  logic                  data_ready
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  logic [WRAP_W-1:0] wrap_cnt;

  rel_edge_counter #(
    .WRAP_W (WRAP_W)
  ) u_rel_edge_counter (
    .clk      (clk),
    .reset    (reset),
    .rel      (rel),
`ifdef COUNT_SAMPLER_OVF_STICKY_EN
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
`endif
    .wrap_cnt (wrap_cnt)
  );

  sampler_state_t            state_q, state_d;
  logic [3:0]                settle_q, settle_d;
  logic                      n_op_en_q, n_op_en_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic [WRAP_W+Q_W-1:0]     data_q, data_d;

  // Outputs are computed for the state being entered so they stay registered.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    n_op_en_d = n_op_en_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (sample_req) begin
          state_d   = ENABLE;
          settle_d  = SETTLE_LOAD;
          n_op_en_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ENABLE: begin
        if (settle_q == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CAPTURE: begin
        data_d    = {wrap_cnt, q_bus};
        valid_d   = 1'b1;
        n_op_en_d = 1'b1;
        state_d   = PRESENT;
      end
      PRESENT: begin
        if (data_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        n_op_en_d = 1'b1;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      settle_q  <= 4'd0;
      n_op_en_q <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      n_op_en_q <= n_op_en_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  assign n_op_en    = n_op_en_q;
  assign busy       = busy_q;
  assign data_valid = valid_q;
  assign data_out   = data_q;

endmodule

`default_nettype wire

// File: tb/tb_count_sampler.sv
// ============================================================================
// tb_count_sampler : directed stimulus with a timeline model of count_sampler.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_count_sampler;

  localparam int Q_W        = 16;
  localparam int WRAP_W     = 16;
  localparam int SETTLE_CYC = 1;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        rel        = 1'b0;
  logic        sample_req = 1'b0;
  logic        data_ready = 1'b1;
  logic [15:0] q_val      = 16'h0;
  logic [15:0] q_bus;
  logic        n_op_en;
  logic        busy;
  logic        data_valid;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Released bus reads as a recognisable junk value.
  assign q_bus = n_op_en ? 16'hDEAD : q_val;

`ifdef COUNT_SAMPLER_OVF_STICKY_EN
  logic        ovf_clr = 1'b0;
  logic        ovf1;
  logic        ovf2;
  logic        n_op_en2;
  logic        busy2;
  logic        data_valid2;
  logic [17:0] data_out2;
`endif

  count_sampler #(
    .Q_W        (Q_W),
    .WRAP_W     (WRAP_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .q_bus      (q_bus),
    .rel        (rel),
    .n_op_en    (n_op_en),
    .sample_req (sample_req),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
`ifdef COUNT_SAMPLER_OVF_STICKY_EN
    .ovf_clr    (ovf_clr),
    .ovf        (ovf1),
`endif
    .data_ready (data_ready)
  );

`ifdef COUNT_SAMPLER_OVF_STICKY_EN
  count_sampler #(
    .Q_W        (16),
    .WRAP_W     (2),
    .SETTLE_CYC (1)
  ) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .q_bus      (q_val),
    .rel        (rel),
    .n_op_en    (n_op_en2),
    .sample_req (sample_req),
    .busy       (busy2),
    .data_out   (data_out2),
    .data_valid (data_valid2),
    .ovf_clr    (ovf_clr),
    .ovf        (ovf2),
    .data_ready (data_ready)
  );
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a request starts a transaction at edge k, the capture happens at
  // edge k+SETTLE_CYC+1, and the word is offered until ready is seen.
  int          cyc;
  int          m_req;
  logic        m_rel_prev;
  logic [15:0] m_wrap;
  logic        m_busy;
  logic        m_valid;
  logic [31:0] m_word;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc        <= 0;
      m_req      <= 0;
      m_rel_prev <= 1'b0;
      m_wrap     <= 16'h0;
      m_busy     <= 1'b0;
      m_valid    <= 1'b0;
      m_word     <= 32'h0;
    end else begin
      cyc        <= cyc + 1;
      m_rel_prev <= rel;
      if (rel && !m_rel_prev) m_wrap <= m_wrap + 16'd1;
      if (!m_busy) begin
        if (sample_req) begin
          m_busy <= 1'b1;
          m_req  <= cyc;
        end
      end else if (!m_valid) begin
        if (cyc == m_req + SETTLE_CYC + 1) begin
          m_valid <= 1'b1;
          m_word  <= {m_wrap, q_val};
        end
      end else if (data_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_n_op_en", 64'(n_op_en), 64'(!(m_busy && !m_valid)));
    check("cmp_busy", 64'(busy), 64'(m_busy));
    check("cmp_data_valid", 64'(data_valid), 64'(m_valid));
    check("cmp_data_out", 64'(data_out), 64'(m_word));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_valid_timeout"}, 64'(data_valid), 64'd1);
  endtask

  task automatic pulse_req();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  initial begin
    int          lows;
    logic [9:0]  rel_seq;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      #3;
      check("idle_n_op_en", 64'(n_op_en), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_data_valid", 64'(data_valid), 64'd0);
      check("idle_data_out", 64'(data_out), 64'd0);
      tick();
    end

    // Single sample, Q = 2, consumer always ready.
    q_val      = 16'h0002;
    data_ready = 1'b1;
    pulse_req();
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      #3;
      if (!n_op_en) lows++;
      if (i == 2) begin
        check("s1_valid_at_n3", 64'(data_valid), 64'd1);
        check("s1_data_out", 64'(data_out), 64'h0000_0002);
      end
      if (i == 3) check("s1_valid_drop", 64'(data_valid), 64'd0);
      tick();
    end
    check("s1_oe_low_cycles", 64'(lows), 64'd2);

    // Four rel rising edges, the second held for three cycles.
    rel_seq = 10'b0101011101;
    for (int i = 0; i < 10; i++) begin
      rel = rel_seq[i];
      tick();
    end
    rel = 1'b0;
    tick();
    q_val = 16'h0001;
    pulse_req();
    wait_valid("s2");
    check("s2_data_out", 64'(data_out), 64'h0004_0001);
`ifdef COUNT_SAMPLER_OVF_STICKY_EN
    check("ovf_wide_clear", 64'(ovf1), 64'd0);
    check("ovf_narrow_set", 64'(ovf2), 64'd1);
    check("ovf_narrow_wrap0", 64'(data_out2), 64'h0_0001);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_narrow_cleared", 64'(ovf2), 64'd0);
`endif
    tick();

    // Back-pressure: word must hold, extra requests must be dropped.
    data_ready = 1'b0;
    q_val      = 16'h1234;
    pulse_req();
    wait_valid("s3");
    check("s3_data_out", 64'(data_out), 64'h0004_1234);
    for (int i = 0; i < 6; i++) begin
      sample_req = (i % 2) == 0;
      tick();
      check("s3_hold_valid", 64'(data_valid), 64'd1);
      check("s3_hold_data", 64'(data_out), 64'h0004_1234);
    end
    sample_req = 1'b1;
    data_ready = 1'b1;
    tick();
    sample_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("s3_no_requeue_busy", 64'(busy), 64'd0);
      check("s3_no_requeue_valid", 64'(data_valid), 64'd0);
      tick();
    end

    // Reset while the bus is enabled.
    q_val = 16'h0005;
    pulse_req();
    check("s4_in_enable", 64'(n_op_en), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("s4_reset_n_op_en", 64'(n_op_en), 64'd1);
    check("s4_reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("s4_no_valid", 64'(data_valid), 64'd0);
      tick();
    end
    pulse_req();
    wait_valid("s5");
    check("s5_wrap_cleared", 64'(data_out), 64'h0000_0005);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
